// File: rtl/gcore_pkg.sv
// Shared types and constants for the op-memory path.
// Imported by the RAM and controller.
package gcore_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_LOAD
  } state_t;

  localparam int OP_W_DEF  = 8;
  localparam int DEPTH_DEF = 256;
  localparam int NOP_OP    = 0;

endpackage

// File: rtl/opram_sp_ram.sv
// Inferred single-port synchronous RAM.
// Registered read, read-before-write.
module opram_sp_ram
  import gcore_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [OP_W-1:0]   din,
  output logic [OP_W-1:0]   dout
);

  logic [OP_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/opram_loader.sv
// Op RAM controller: streaming program loader
// arbitrated against the core fetch port.
module opram_loader
  import gcore_pkg::*;
#(
  parameter int OP_W  = OP_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [OP_W-1:0]   load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_full,
  output logic [ADDR_W:0]   prog_len,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [OP_W-1:0]   fetch_op,
  output logic              fetch_err,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [OP_W-1:0]   NOP    = OP_W'(NOP_OP);

  state_t            state;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] ram_addr;
  logic [OP_W-1:0]   ram_dout;
  logic [OP_W-1:0]   op_hold;
  logic              we;
  logic              fetch_acc;
  logic              in_range;

  assign busy        = (state == ST_LOAD);
  assign load_ready  = (state == ST_LOAD);
  assign fetch_ready = (state == ST_IDLE);
  assign we          = load_ready && load_valid;
  assign ram_addr    = we ? wptr : fetch_addr;
  assign fetch_acc   = fetch_req && fetch_ready;
  assign in_range    = ({1'b0, fetch_addr} < prog_len);

  opram_sp_ram #(
    .OP_W (OP_W),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk (clk),
    .we  (we),
    .addr(ram_addr),
    .din (load_data),
    .dout(ram_dout)
  );

  // RAM dout changes every cycle, so the op is held between fetches.
  assign fetch_op = !fetch_valid ? op_hold :
                    fetch_err    ? NOP     : ram_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wptr        <= '0;
      prog_len    <= '0;
      load_full   <= 1'b0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      op_hold     <= '0;
    end else begin
      load_done   <= 1'b0;
      fetch_valid <= fetch_acc;
      fetch_err   <= fetch_acc && !in_range;
      op_hold     <= fetch_op;
      unique case (state)
        ST_IDLE: begin
          if (load_start) begin
            state     <= ST_LOAD;
            wptr      <= '0;
            prog_len  <= '0;
            load_full <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (load_valid) begin
            wptr     <= wptr + 1'b1;
            prog_len <= {1'b0, wptr} + 1'b1;
            if (wptr == LAST_A) begin
              state     <= ST_IDLE;
              load_done <= 1'b1;
              load_full <= 1'b1;
            end else if (load_last) begin
              state     <= ST_IDLE;
              load_done <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opram_loader.sv
// Scoreboard bench for opram_loader.
// Expected fetch results are queued on issue, popped on fetch_valid.
module tb_opram_loader;

  localparam int OP_W   = 8;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic              load_valid;
  logic [OP_W-1:0]   load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              load_full;
  logic [ADDR_W:0]   prog_len;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [OP_W-1:0]   fetch_op;
  logic              fetch_err;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  logic [OP_W-1:0] mem [DEPTH];
  int              mlen = 0;
  logic [OP_W-1:0] vals [DEPTH];
  logic [OP_W:0]   sb [$];

  always #5 clk = ~clk;

  opram_loader #(
    .OP_W (OP_W),
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_full  (load_full),
    .prog_len   (prog_len),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid),
    .fetch_op   (fetch_op),
    .fetch_err  (fetch_err),
    .busy       (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && fetch_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        logic [OP_W:0] e;
        e = sb.pop_front();
        chk("fetch_op", 32'(fetch_op), 32'(e[OP_W-1:0]));
        chk("fetch_err", 32'(fetch_err), 32'(e[OP_W]));
      end
    end
  end

  function automatic logic [OP_W:0] expect_fetch(int a);
    if (a < mlen) return {1'b0, mem[a]};
    return {1'b1, {OP_W{1'b0}}};
  endfunction

  task automatic fetch(input int a);
    fetch_req  = 1'b1;
    fetch_addr = ADDR_W'(a);
    chk("fetch_ready", 32'(fetch_ready), 32'd1);
    sb.push_back(expect_fetch(a));
    tick();
    fetch_req = 1'b0;
    tick();
  endtask

  // Streams n words from vals[]; gap idle cycles after each word.
  task automatic do_load(input int n, input bit use_last,
                         input int gap, input bit poke_fetch);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    mlen = 0;
    for (int i = 0; i < n; i++) begin
      chk("load_ready", 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      load_data  = vals[i];
      load_last  = use_last && (i == n - 1);
      mem[i]     = vals[i];
      mlen       = i + 1;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      if (i != n - 1) begin
        for (int g = 0; g < gap; g++) begin
          chk("ready_gap", 32'(load_ready), 32'd1);
          fetch_req  = poke_fetch;
          fetch_addr = '0;
          if (poke_fetch)
            chk("fready_load", 32'(fetch_ready), 32'd0);
          tick();
          fetch_req = 1'b0;
        end
      end
    end
    chk("load_done", 32'(load_done), 32'd1);
    chk("prog_len", 32'(prog_len), 32'(n));
    tick();
    chk("done_pulse", 32'(load_done), 32'd0);
    chk("busy_drop", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_len", 32'(prog_len), 32'd0);
    chk("rst_full", 32'(load_full), 32'd0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_op", 32'(fetch_op), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_lready", 32'(load_ready), 32'd0);
    chk("rst_fready", 32'(fetch_ready), 32'd1);

    vals[0] = 8'h11; vals[1] = 8'h22;
    vals[2] = 8'h33; vals[3] = 8'h44;
    do_load(4, 1'b1, 0, 1'b0);
    chk("t1_full", 32'(load_full), 32'd0);
    fetch(2);
    fetch(4);
    fetch(3);

    for (int i = 0; i < DEPTH; i++) vals[i] = OP_W'(i);
    do_load(DEPTH, 1'b0, 0, 1'b0);
    chk("t3_full", 32'(load_full), 32'd1);
    fetch(255);
    fetch(0);

    vals[0] = 8'hA1; vals[1] = 8'hB2; vals[2] = 8'hC3;
    do_load(3, 1'b1, 2, 1'b1);
    chk("t4_full_clr", 32'(load_full), 32'd0);
    fetch(2);
    fetch(3);

    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1;
      load_data  = OP_W'(8'h50 + i);
      mem[i]     = load_data;
      tick();
    end
    load_valid = 1'b0;
    rst = 1'b1;
    mlen = 0;
    tick();
    rst = 1'b0;
    chk("t5_len", 32'(prog_len), 32'd0);
    chk("t5_done", 32'(load_done), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    fetch(0);

    vals[0] = 8'h01; vals[1] = 8'h02;
    vals[2] = 8'h03; vals[3] = 8'h04;
    do_load(4, 1'b1, 0, 1'b0);
    load_start = 1'b1;
    fetch_req  = 1'b1;
    fetch_addr = 8'd1;
    chk("t6_fready", 32'(fetch_ready), 32'd1);
    sb.push_back(expect_fetch(1));
    tick();
    load_start = 1'b0;
    fetch_req  = 1'b0;
    chk("t6_busy", 32'(busy), 32'd1);
    vals[0] = 8'hE0; vals[1] = 8'hE1;
    vals[2] = 8'hE2; vals[3] = 8'hE3;
    mlen = 0;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = vals[i];
      load_last  = (i == 3);
      mem[i]     = vals[i];
      mlen       = i + 1;
      tick();
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    chk("t6_done", 32'(load_done), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      fetch_req  = 1'b1;
      fetch_addr = ADDR_W'(i);
      sb.push_back(expect_fetch(i));
      tick();
      chk("b2b_valid", 32'(fetch_valid), 32'd1);
    end
    fetch_req = 1'b0;
    tick();
    chk("b2b_end", 32'(fetch_valid), 32'd0);
    tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
